// File: rtl/rca_operand_feeder_if.sv
// Bundle between the operand feeder, its producer/consumer and the external adder.
// Optional out_ovf is present only when RCA_FEEDER_OVF_EN is defined.
interface rca_operand_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [CW-1:0]    fifo_count;
`ifdef RCA_FEEDER_OVF_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, fifo_count, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, fifo_count, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, fifo_count
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, fifo_count
  );
`endif
endinterface

// File: rtl/rca_operand_feeder.sv
// Operand FIFO in front of an external ripple-carry adder, with a registered valid/ready result.
// Define RCA_FEEDER_OVF_EN to add the registered signed-overflow flag out_ovf.
module rca_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rca_operand_feeder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  op_t              mem_q [DEPTH];
  op_t              head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             empty, push, pop;

  assign empty        = (cnt_q == '0);
  // Ready depends only on the registered count; a same-cycle pop never frees a slot early.
  assign bus.in_ready = (cnt_q != CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = !empty & (!out_valid_q | bus.out_ready);

  assign head        = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.add_a   = head.a;
  assign bus.add_b   = head.b;
  assign bus.add_cin = head.cin;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      out_valid_d = 1'b1;
      sum_d       = bus.add_sum;
      cout_d      = bus.add_cout;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: bus.in_a, b: bus.in_b, cin: bus.in_cin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_cout   = cout_q;
  assign bus.fifo_count = cnt_q;

`ifdef RCA_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  // Same-sign operands whose sum flips sign overflowed in two's complement.
  always_comb begin
    ovf_d = ovf_q;
    if (pop) ovf_d = (head.a[WIDTH-1] == head.b[WIDTH-1]) & (bus.add_sum[WIDTH-1] != head.a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca_operand_feeder.sv
// Bench for rca_operand_feeder: adder model on the add_* bus, scoreboard of accepted triples.
module tb_rca_operand_feeder;
  logic clk;
  logic rst_n;
  int   nchecks = 0;
  int   nerrs   = 0;

  rca_operand_feeder_if #(.WIDTH(8), .DEPTH(4)) bus ();

  rca_operand_feeder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External ripple-carry adder stand-in.
  assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + bus.add_cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  res_t exp_q[$];
  logic       hold_v;
  logic [7:0] hold_sum;
  logic       hold_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    res_t r;
    int   u, sa, sb, ss;
    u  = int'(a) + int'(b) + int'(cin);
    sa = $signed(a);
    sb = $signed(b);
    ss = sa + sb + int'(cin);
    r.sum  = u[7:0];
    r.cout = (u > 255);
    r.ovf  = (ss > 127) || (ss < -128);
    return r;
  endfunction

  // Scoreboard: every held result must match the oldest unconsumed accepted triple.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_valid", 32'(bus.out_valid), 32'd1);
        chk("stable_sum", 32'(bus.out_sum), 32'(hold_sum));
        chk("stable_cout", 32'(bus.out_cout), 32'(hold_cout));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          chk("sb_sum", 32'(bus.out_sum), 32'(exp_q[0].sum));
          chk("sb_cout", 32'(bus.out_cout), 32'(exp_q[0].cout));
`ifdef RCA_FEEDER_OVF_EN
          chk("sb_ovf", 32'(bus.out_ovf), 32'(exp_q[0].ovf));
`endif
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      chk("count_bound", 32'(bus.fifo_count <= 3'd4), 32'd1);
      hold_v    = bus.out_valid & !bus.out_ready;
      hold_sum  = bus.out_sum;
      hold_cout = bus.out_cout;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  int   acc;

  initial begin
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_add_a_empty", 32'(bus.add_a), 32'd0);
`ifdef RCA_FEEDER_OVF_EN
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    cyc();

    // Single pushes with 1-cycle latency.
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      bus.in_valid = 1'b1;
      bus.in_a = vecs[i].a; bus.in_b = vecs[i].b; bus.in_cin = vecs[i].cin;
      cyc();
      bus.in_valid = 1'b0;
      chk("vec_count_after_push", 32'(bus.fifo_count), 32'd1);
      chk("vec_valid_latency0", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("vec_valid", 32'(bus.out_valid), 32'd1);
      chk("vec_sum", 32'(bus.out_sum), 32'(vecs[i].sum));
      chk("vec_cout", 32'(bus.out_cout), 32'(vecs[i].cout));
`ifdef RCA_FEEDER_OVF_EN
      chk("vec_ovf", 32'(bus.out_ovf), 32'(vecs[i].ovf));
`endif
    end
    cyc();
    chk("vec_drained", 32'(bus.out_valid), 32'd0);

    // Back-pressure: DEPTH+1 in flight, then ordered drain.
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'(i); bus.in_b = 8'h00; bus.in_cin = 1'b0;
      if (bus.in_ready) acc++;
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_count_full", 32'(bus.fifo_count), 32'd4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_held_sum", 32'(bus.out_sum), 32'h01);
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      cyc();
      chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_drain_sum", 32'(bus.out_sum), 32'(k));
    end
    cyc();
    chk("bp_drain_done", 32'(bus.out_valid), 32'd0);

    // Streaming: one result per cycle.
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'(i + 8'h10); bus.in_b = 8'h03; bus.in_cin = 1'(i);
      cyc();
      chk("stream_count", 32'(bus.fifo_count <= 3'd1), 32'd1);
      if (i > 0) chk("stream_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    cyc(); cyc();
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'(8'h20 + i); bus.in_b = 8'h01; bus.in_cin = 1'b0;
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    #6;
    rst_n = 1'b1;
    cyc();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_cin = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_sum", 32'(bus.out_sum), 32'h47);
    chk("post_rst_cout", 32'(bus.out_cout), 32'd0);
    cyc();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.in_cin    = 1'($urandom);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) cyc();
    chk("rand_no_drops", 32'(exp_q.size()), 32'd0);
    chk("rand_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("rand_idle_count", 32'(bus.fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
